cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_controller_instr_dec.sv | 27 ++
 rtl/cpu_controller.sv | 161 ++++++++++++++++
 tb/tb_cpu_controller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction controller.
// CTRL_TRAP_EN adds a HALT state for illegal instructions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
`ifdef CTRL_TRAP_EN
    ,
    S_HALT      = 3'd7
`endif
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [1:0] VSEL_IMM8 = 2'b01;
  localparam logic [1:0] VSEL_C    = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Field extraction and immediate sign extension for the IR.
// Purely combinational.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [1:0]  o_sh,
  output logic [2:0]  o_rm,
  output logic [15:0] o_sximm8,
  output logic [15:0] o_sximm5
);

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];

  assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Moore FSM sequencing the datapath for MOV/ADD/CMP/AND/MVN.
// Define CTRL_TRAP_EN to halt with a sticky err on illegal code.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;
  logic       w_mov_imm;
  logic       w_mov_reg;
  logic       w_alu;

  instr_dec u_dec (
    .i_ir     (r_ir),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_sh     (w_sh),
    .o_rm     (w_rm),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  assign w_mov_imm = (w_opcode == OPC_MOV) && (w_op == OP_MOV_IMM);
  assign w_mov_reg = (w_opcode == OPC_MOV) && (w_op == OP_MOV_REG);
  assign w_alu     = (w_opcode == OPC_ALU);

  // IR accepts a new word only while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_ir <= 16'h0000;
    else if (r_state == S_WAIT && load)
      r_ir <= in;
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_WAIT;
    else
      r_state <= w_next;
  end

  // next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT:
        if (s) w_next = S_DECODE;
      S_DECODE:
        unique case (1'b1)
          w_mov_imm: w_next = S_WRITE_IMM;
          w_mov_reg: w_next = S_GET_B;
          w_alu:     w_next = S_GET_A;
`ifdef CTRL_TRAP_EN
          default:   w_next = S_HALT;
`else
          default:   w_next = S_WAIT;
`endif
        endcase
      S_WRITE_IMM: w_next = S_WAIT;
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_ALU;
      S_ALU:
        if (w_alu && w_op == ALU_CMP)
          w_next = S_WAIT;
        else
          w_next = S_WRITE_REG;
      S_WRITE_REG: w_next = S_WAIT;
`ifdef CTRL_TRAP_EN
      S_HALT:      w_next = S_HALT;
`endif
      default:     w_next = S_WAIT;
    endcase
  end

  // Moore output decode from state and IR only
  always_comb begin
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;
    unique case (r_state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        shift   = w_sh;
      end
      S_ALU: begin
        loadc = 1'b1;
        shift = w_sh;
        asel  = w_mov_reg;
        ALUop = w_alu ? w_op : ALU_ADD;
        loads = w_alu && (w_op == ALU_CMP);
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_TRAP_EN
  assign err = (r_state == S_HALT);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with an expectation queue.
// Each step pushes the expected outputs, then pops at the edge.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  cpu_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .load     (load),
    .in       (in),
    .w        (w),
    .err      (err),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic out_t snap();
    out_t o;
    o = {w, err, readnum, writenum, write, loada, loadb,
         loadc, loads, asel, bsel, vsel, shift, ALUop};
    return o;
  endfunction

  function automatic out_t o_idle();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t o_wait();
    out_t o;
    o = '0;
    o.w = 1'b1;
    return o;
  endfunction

  function automatic out_t o_imm(logic [2:0] rn);
    out_t o;
    o = '0;
    o.writenum = rn;
    o.vsel = 2'b01;
    o.write = 1'b1;
    return o;
  endfunction

  function automatic out_t o_geta(logic [2:0] rn);
    out_t o;
    o = '0;
    o.readnum = rn;
    o.loada = 1'b1;
    return o;
  endfunction

  function automatic out_t o_getb(logic [2:0] rm, logic [1:0] sh);
    out_t o;
    o = '0;
    o.readnum = rm;
    o.loadb = 1'b1;
    o.shift = sh;
    return o;
  endfunction

  function automatic out_t o_alu(logic a, logic [1:0] op,
                                 logic ld_s, logic [1:0] sh);
    out_t o;
    o = '0;
    o.loadc = 1'b1;
    o.asel = a;
    o.aluop = op;
    o.loads = ld_s;
    o.shift = sh;
    return o;
  endfunction

  function automatic out_t o_wreg(logic [2:0] rd);
    out_t o;
    o = '0;
    o.writenum = rd;
    o.vsel = 2'b11;
    o.write = 1'b1;
    return o;
  endfunction

  task automatic push(string tag, out_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    out_t  e;
    out_t  a;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    a = snap();
    n_vec++;
    assert (a === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, a, e);
    end
  endtask

  task automatic step(string tag, out_t e);
    push(tag, e);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic now(string tag, out_t e);
    push(tag, e);
    compare();
  endtask

  task automatic chk16(string tag, logic [15:0] got,
                       logic [15:0] want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    s = 1'b0;
    load = 1'b0;
    in = 16'h0000;
    #1 reset_n = 1'b0;
    #1;
    now("reset", o_wait());
    chk16("reset_ir", sximm8, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    step("first_wait", o_wait());

    // MOV R0,#-5
    in = 16'hD0FB;
    load = 1'b1;
    step("movi_load", o_wait());
    load = 1'b0;
    chk16("movi_sx8", sximm8, 16'hFFFB);
    chk16("movi_sx5", sximm5, 16'hFFFB);
    s = 1'b1;
    step("movi_dec", o_idle());
    s = 1'b0;
    step("movi_wr", o_imm(3'd0));
    step("movi_done", o_wait());

    // ADD R2,R1,R0 with a load pulse while busy
    in = 16'hA140;
    load = 1'b1;
    step("add_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("add_dec", o_idle());
    s = 1'b0;
    step("add_geta", o_geta(3'd1));
    in = 16'hD007;
    load = 1'b1;
    s = 1'b1;
    step("add_getb", o_getb(3'd0, 2'b00));
    load = 1'b0;
    s = 1'b0;
    chk16("add_ir_kept", sximm8, 16'h0040);
    step("add_alu", o_alu(1'b0, 2'b00, 1'b0, 2'b00));
    step("add_wr", o_wreg(3'd2));
    step("add_done", o_wait());

    // CMP R0,R1
    in = 16'hA801;
    load = 1'b1;
    step("cmp_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("cmp_dec", o_idle());
    s = 1'b0;
    step("cmp_geta", o_geta(3'd0));
    step("cmp_getb", o_getb(3'd1, 2'b00));
    step("cmp_alu", o_alu(1'b0, 2'b01, 1'b1, 2'b00));
    step("cmp_done", o_wait());

    // MOV R3,R2 shifted by 01
    in = 16'hC06A;
    load = 1'b1;
    step("movr_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("movr_dec", o_idle());
    s = 1'b0;
    step("movr_getb", o_getb(3'd2, 2'b01));
    step("movr_alu", o_alu(1'b1, 2'b00, 1'b0, 2'b01));
    step("movr_wr", o_wreg(3'd3));
    step("movr_done", o_wait());

    // AND R4,R3,R5 shifted by 10
    in = 16'hB395;
    load = 1'b1;
    step("and_load", o_wait());
    load = 1'b0;
    chk16("and_sx8", sximm8, 16'hFF95);
    chk16("and_sx5", sximm5, 16'hFFF5);
    s = 1'b1;
    step("and_dec", o_idle());
    s = 1'b0;
    step("and_geta", o_geta(3'd3));
    step("and_getb", o_getb(3'd5, 2'b10));
    step("and_alu", o_alu(1'b0, 2'b10, 1'b0, 2'b10));
    step("and_wr", o_wreg(3'd4));
    step("and_done", o_wait());

    // back-to-back MOV R3,#5 with s held high
    in = 16'hD305;
    load = 1'b1;
    step("b2b_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("b2b_dec1", o_idle());
    step("b2b_wr1", o_imm(3'd3));
    step("b2b_wait", o_wait());
    step("b2b_dec2", o_idle());
    step("b2b_wr2", o_imm(3'd3));
    s = 1'b0;
    step("b2b_done", o_wait());
    step("b2b_idle", o_wait());

    // illegal opcode 111
    in = 16'hE000;
    load = 1'b1;
    step("ill_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("ill_dec", o_idle());
    s = 1'b0;
`ifdef CTRL_TRAP_EN
    begin
      out_t h;
      h = '0;
      h.err = 1'b1;
      step("ill_halt", h);
      s = 1'b1;
      step("ill_halt2", h);
      s = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    now("ill_reset", o_wait());
    @(negedge clk);
    reset_n = 1'b1;
    step("ill_after", o_wait());
`else
    step("ill_wait", o_wait());
    step("ill_stay", o_wait());
`endif

    // reset in the middle of ADD
    in = 16'hA140;
    load = 1'b1;
    step("rst_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("rst_dec", o_idle());
    s = 1'b0;
    step("rst_geta", o_geta(3'd1));
    step("rst_getb", o_getb(3'd0, 2'b00));
    #2 reset_n = 1'b0;
    #1;
    now("rst_async", o_wait());
    chk16("rst_ir", sximm8, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    step("rst_next", o_wait());

    // MOV R7,#1 runs normally afterwards
    in = 16'hD701;
    load = 1'b1;
    step("post_load", o_wait());
    load = 1'b0;
    s = 1'b1;
    step("post_dec", o_idle());
    s = 1'b0;
    step("post_wr", o_imm(3'd7));
    step("post_done", o_wait());

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
